// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-read-port register file with an optional
//            hardwired-zero r0, write-to-read bypass and a busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     alloc,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    logic              wr_ok;
    logic              alloc_ok;
    logic              busy_set;
    logic              busy_clr;
    logic [ADDR_W-1:0] rd_addr;

    // Writes and allocs are suppressed during reset and when aimed at a hardwired r0.
    always_comb begin
        wr_ok    = we    & ~rst & ~((ZERO_REG != 0) & (waddr == '0));
        alloc_ok = alloc & ~rst & ~((ZERO_REG != 0) & (alloc_addr == '0));
        busy_set = alloc_ok & ~busy_q[alloc_addr];
        busy_clr = wr_ok & busy_q[waddr] & ~(alloc_ok & (alloc_addr == waddr));
    end

    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_d[r] = '0;
            end
            busy_d     = '0;
            busy_cnt_d = '0;
        end else begin
            if (wr_ok) begin
                regs_d[waddr] = wdata;
                busy_d[waddr] = 1'b0;
            end
            // Alloc applied after the write so a new producer wins on a collision.
            if (alloc_ok) begin
                busy_d[alloc_addr] = 1'b1;
            end
            busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, busy_set}
                                    - {{ADDR_W{1'b0}}, busy_clr};
        end
    end

    always_ff @(posedge clk) begin
        regs_q     <= regs_d;
        busy_q     <= busy_d;
        busy_cnt_q <= busy_cnt_d;
    end

    always_comb begin
        rdata   = '0;
        rbusy   = '0;
        rd_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr = raddr[i*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rdata[i*DATA_W +: DATA_W] = '0;
                rbusy[i]                  = 1'b0;
            end else if ((BYPASS != 0) && wr_ok && (waddr == rd_addr)) begin
                rdata[i*DATA_W +: DATA_W] = wdata;
                // A same-cycle alloc cancels the clear bypass but never raises busy itself.
                rbusy[i] = alloc_ok && (alloc_addr == rd_addr) && busy_q[rd_addr];
            end else begin
                rdata[i*DATA_W +: DATA_W] = regs_q[rd_addr];
                rbusy[i]                  = busy_q[rd_addr];
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the pipelined core, replacing the fixed 32x32, two-read-port register file. It has configurable data width, depth and read-port count, an optional hardwired-zero register 0, and optional same-cycle write-to-read bypass. A per-register busy scoreboard lets the decode stage detect RAW hazards on registers whose producer has not yet written back. It sits between decode (reads, allocation) and writeback (writes).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data and busy-clear visible on read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write enable (writeback)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- alloc  in  1  mark register alloc_addr busy (decode issues a producer)
- alloc_addr  in  ADDR_W  register to mark busy
- raddr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rbusy  out  NUM_RD  busy flag for each read port's register
- busy_cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: DEPTH x DATA_W array plus DEPTH-bit busy vector, both updated only on rising clk edge.
- Reset: when rst = 1 at an edge, every register is cleared to 0, every busy bit is cleared, and busy_cnt goes to 0. we and alloc are ignored during that cycle.
- Write: when we = 1, the edge stores wdata into Regs[waddr] and clears busy[waddr]. If ZERO_REG = 1 and waddr = 0, the write is dropped.
- Alloc: when alloc = 1, the edge sets busy[alloc_addr]. If ZERO_REG = 1 and alloc_addr = 0, the alloc is ignored.
- Simultaneous write and alloc on the same register: data is written, busy ends at 1 (the new producer wins).
- Re-alloc of an already-busy register: no change; busy_cnt is not double-counted.
- Write to a non-busy register: data is written, busy_cnt is unchanged.
- busy_cnt tracks the popcount of the busy vector exactly:
  - +1 for each 0->1 transition, -1 for each 1->0 transition in the same edge.
  - Net 0 when one register is set and a different register is cleared.
  - Never wraps: max DEPTH (or DEPTH-1 with ZERO_REG).
- Read path (combinational, per port i):
  - ZERO_REG = 1 and raddr_i = 0: rdata_i = 0, rbusy_i = 0.
  - Else if BYPASS = 1, we = 1 and waddr = raddr_i (write not dropped): rdata_i = wdata, and rbusy_i = 0 unless alloc = 1 with alloc_addr = raddr_i.
  - Else: rdata_i = Regs[raddr_i], rbusy_i = busy[raddr_i].
  - Same-cycle alloc never raises rbusy; busy is visible from the next cycle.
- All read ports are independent; any number may address the same register.

## Timing
- Write latency: 1 cycle; without bypass, data is readable the cycle after we.
- With BYPASS = 1, read-after-write latency is 0 (same cycle).
- Alloc-to-rbusy latency: 1 cycle.
- Reset takes effect at the first edge with rst = 1. Outputs read 0 / not busy from the following cycle and hold while rst stays high.
- Reset asserted mid-sequence (busy registers outstanding): all busy bits are lost. A later write to a formerly busy register must not underflow busy_cnt.
- No handshake; writes and allocs are accepted every cycle.

## Test plan
- Reset: write 0xDEADBEEF to r5, allocate r7, assert rst for 1 cycle -> rdata(r5) = 0, rbusy(r7) = 0, busy_cnt = 0.
- Zero register: we = 1, waddr = 0, wdata = 0xFFFFFFFF, alloc r0 -> rdata(r0) = 0, rbusy = 0, busy_cnt = 0. Repeat with ZERO_REG = 0 -> r0 reads 0xFFFFFFFF.
- Bypass: BYPASS = 1, write r3 = 0x12345678 while both ports read r3 -> both rdata = 0x12345678 in the same cycle. With BYPASS = 0 -> old value that cycle, new value the next.
- Scoreboard: alloc r10 -> rbusy(r10) = 1 next cycle, busy_cnt = 1. Write r10 = 0xA5 -> rbusy drops the same cycle (BYPASS = 1), busy_cnt = 0 after the edge.
- Simultaneous events: alloc r4 and write r4 = 0x55 in one cycle -> r4 = 0x55, busy(r4) = 1, busy_cnt +1. Alloc r6 while writing busy r9 -> busy_cnt unchanged.
- Random sweep, NUM_RD = 4, ADDR_W = 3: compare 10k cycles of random we/alloc/raddr/rst against a reference model. rdata, rbusy and busy_cnt must match every cycle.
